// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by fetch and the decode pipeline register.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push, pop and a flush that overrides both.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: drives imem, queues returned words with their PC, handles redirects.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Halt,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         q_full, q_empty;
    logic         push, pop;
    fetch_entry_t head, new_entry;
    logic         unused_target_lsbs;

    assign unused_target_lsbs = ^RedirectTarget[1:0];

    assign OutValid = ~q_empty;
    assign pop      = OutValid & OutReady;
    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign push     = ~Redirect & ~Halt & (~q_full | pop);

    assign new_entry.pc    = fetch_pc_q;
    assign new_entry.instr = ImemInstruction;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Redirect) begin
            fetch_pc_d = {RedirectTarget[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_i        (Clk),
        .rst_i        (Rst),
        .push_i       (push),
        .push_entry_i (new_entry),
        .pop_i        (pop),
        .flush_i      (Redirect),
        .head_o       (head),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    assign ImemAddress    = fetch_pc_q;
    assign OutInstruction = OutValid ? head.instr : NOP_INSTR;
    assign OutPC          = OutValid ? head.pc : 32'h0;
    assign OutPCPlus4     = OutValid ? head.pc + 32'(WORD_BYTES) : 32'h0;

endmodule
